// File: rtl/inst_fetch_unit_if.sv
// Instruction memory read port: request/address out, ack/data back.
interface inst_fetch_unit_if #(
    parameter int unsigned PC_W = 16,
    parameter int unsigned IW   = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [IW-1:0]   imem_data;

    // Fetch unit side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    // Memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and a
// req/ack fetch sequencer with a bounded wait and sticky timeout flag.
module inst_fetch_unit #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned IW      = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic                    i_Pc_Rst,
    input  logic                    i_Pc_Ld,
    input  logic                    i_pc_addr_sel,
    input  logic [PC_W-1:0]         i_imd_addr,
    input  logic [PC_W-1:0]         i_alu_pc_in,
    input  logic                    i_fetch_req,
    inst_fetch_unit_if.master       imem,
    output logic [PC_W-1:0]         o_pc,
    output logic [IW-1:0]           o_inst,
    output logic                    o_inst_valid,
    output logic                    o_busy,
    output logic                    o_fetch_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_ERR  = 2'd2
    } fetch_state_t;

    fetch_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pc_ld_q;
    logic [PC_W-1:0]   r_pc;
    logic [IW-1:0]     r_inst;
    logic [PC_W-1:0]   r_imem_addr;
    logic              r_imem_req;
    logic              r_inst_valid;
    logic              r_busy;
    logic              r_fetch_err;

    logic              w_pc_ld_edge;
    logic [PC_W-1:0]   w_pc_ld_val;
    logic              w_timeout_hit;

    // Load strobe is the rising edge of Pc_Ld so a held request loads once
    assign w_pc_ld_edge  = i_Pc_Ld && !r_pc_ld_q;
    assign w_pc_ld_val   = i_pc_addr_sel ? i_imd_addr : i_alu_pc_in;
    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT - 1));

    // PC register, instruction register and fetch sequencer
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_state      <= F_IDLE;
            r_cnt        <= '0;
            r_pc_ld_q    <= 1'b0;
            r_pc         <= '0;
            r_inst       <= '0;
            r_imem_addr  <= '0;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_pc_ld_q <= i_Pc_Ld;
            if (!i_Pc_Rst) begin
                // PC clear also aborts any fetch; inst keeps its last word
                r_pc         <= '0;
                r_state      <= F_IDLE;
                r_imem_req   <= 1'b0;
                r_busy       <= 1'b0;
                r_inst_valid <= 1'b0;
                r_fetch_err  <= 1'b0;
            end else begin
                if (w_pc_ld_edge) begin
                    r_pc <= w_pc_ld_val;
                end
                case (r_state)
                    F_IDLE: begin
                        if (i_fetch_req) begin
                            r_imem_addr  <= r_pc;
                            r_imem_req   <= 1'b1;
                            r_busy       <= 1'b1;
                            r_inst_valid <= 1'b0;
                            r_fetch_err  <= 1'b0;
                            r_cnt        <= '0;
                            r_state      <= F_REQ;
                        end
                    end
                    F_REQ: begin
                        // Ack wins over a timeout on the same edge
                        if (imem.imem_ack) begin
                            r_inst       <= imem.imem_data;
                            r_inst_valid <= 1'b1;
                            r_imem_req   <= 1'b0;
                            r_busy       <= 1'b0;
                            r_state      <= F_IDLE;
                        end else if (w_timeout_hit) begin
                            r_imem_req <= 1'b0;
                            r_state    <= F_ERR;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    F_ERR: begin
                        r_fetch_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= F_IDLE;
                    end
                    default: begin
                        r_state <= F_IDLE;
                    end
                endcase
            end
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_imem_addr;
    assign o_pc           = r_pc;
    assign o_inst         = r_inst;
    assign o_inst_valid   = r_inst_valid;
    assign o_busy         = r_busy;
    assign o_fetch_err    = r_fetch_err;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, fetch, PC load, timeout, abort.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        Rst;
    logic        Pc_Rst;
    logic        Pc_Ld;
    logic        pc_addr_sel;
    logic [15:0] imd_addr;
    logic [15:0] alu_pc_in;
    logic        fetch_req;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        inst_valid;
    logic        busy;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;

    inst_fetch_unit_if #(.PC_W(16), .IW(16)) bus ();

    inst_fetch_unit #(.PC_W(16), .IW(16), .TIMEOUT(15)) dut (
        .clk           (clk),
        .Rst           (Rst),
        .i_Pc_Rst      (Pc_Rst),
        .i_Pc_Ld       (Pc_Ld),
        .i_pc_addr_sel (pc_addr_sel),
        .i_imd_addr    (imd_addr),
        .i_alu_pc_in   (alu_pc_in),
        .i_fetch_req   (fetch_req),
        .imem          (bus.master),
        .o_pc          (pc),
        .o_inst        (inst),
        .o_inst_valid  (inst_valid),
        .o_busy        (busy),
        .o_fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Rst           = 1'b0;
        Pc_Rst        = 1'b1;
        Pc_Ld         = 1'b0;
        pc_addr_sel   = 1'b0;
        imd_addr      = 16'h0000;
        alu_pc_in     = 16'h0000;
        fetch_req     = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'h0000;
        #1;
        check("rst_pc",    32'(pc), 32'h0);
        check("rst_inst",  32'(inst), 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_req",   32'(bus.imem_req), 32'h0);
        check("rst_addr",  32'(bus.imem_addr), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_err",   32'(fetch_err), 32'h0);
        step();
        step();
        Rst = 1'b1;

        // Reset mid-fetch
        Pc_Ld = 1'b1; pc_addr_sel = 1'b0; alu_pc_in = 16'h0007;
        step();
        Pc_Ld = 1'b0;
        check("mf_pc_load", 32'(pc), 32'h0007);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("mf_req", 32'(bus.imem_req), 32'h1);
        check("mf_addr", 32'(bus.imem_addr), 32'h0007);
        check("mf_busy", 32'(busy), 32'h1);
        step();
        #2;
        Rst = 1'b0;
        #1;
        check("mf_async_pc",   32'(pc), 32'h0);
        check("mf_async_req",  32'(bus.imem_req), 32'h0);
        check("mf_async_addr", 32'(bus.imem_addr), 32'h0);
        check("mf_async_busy", 32'(busy), 32'h0);
        #1;
        Rst = 1'b1;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("mf_refetch_req", 32'(bus.imem_req), 32'h1);
        check("mf_refetch_addr", 32'(bus.imem_addr), 32'h0000);
        bus.imem_ack = 1'b1; bus.imem_data = 16'h1111;
        step();
        bus.imem_ack = 1'b0;
        check("mf_done_inst", 32'(inst), 32'h1111);
        check("mf_done_valid", 32'(inst_valid), 32'h1);

        // Basic fetch from pc 0x0004, ack three cycles later
        Pc_Ld = 1'b1; pc_addr_sel = 1'b0; alu_pc_in = 16'h0004;
        step();
        Pc_Ld = 1'b0;
        check("bf_pc", 32'(pc), 32'h0004);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("bf_req", 32'(bus.imem_req), 32'h1);
        check("bf_addr", 32'(bus.imem_addr), 32'h0004);
        check("bf_valid_clr", 32'(inst_valid), 32'h0);
        step();
        step();
        bus.imem_ack = 1'b1; bus.imem_data = 16'h2465;
        step();
        bus.imem_ack = 1'b0;
        check("bf_inst", 32'(inst), 32'h2465);
        check("bf_valid", 32'(inst_valid), 32'h1);
        check("bf_busy", 32'(busy), 32'h0);
        check("bf_req_drop", 32'(bus.imem_req), 32'h0);
        step();
        check("bf_valid_hold", 32'(inst_valid), 32'h1);

        // PC load edge detection: held Pc_Ld loads once
        Pc_Ld = 1'b1; pc_addr_sel = 1'b0; alu_pc_in = 16'h0005;
        step();
        check("ld_first", 32'(pc), 32'h0005);
        alu_pc_in = 16'h0055;
        step();
        step();
        check("ld_once", 32'(pc), 32'h0005);
        Pc_Ld = 1'b0;
        step();
        pc_addr_sel = 1'b1; imd_addr = 16'h03F0; Pc_Ld = 1'b1;
        step();
        Pc_Ld = 1'b0;
        check("ld_imd", 32'(pc), 32'h03F0);

        // Timeout with no ack
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("to_req", 32'(bus.imem_req), 32'h1);
        repeat (14) step();
        check("to_req_14", 32'(bus.imem_req), 32'h1);
        check("to_err_14", 32'(fetch_err), 32'h0);
        step();
        check("to_req_15", 32'(bus.imem_req), 32'h0);
        check("to_err_15", 32'(fetch_err), 32'h0);
        step();
        check("to_err_16", 32'(fetch_err), 32'h1);
        check("to_busy_16", 32'(busy), 32'h0);
        check("to_inst_keep", 32'(inst), 32'h2465);
        check("to_valid", 32'(inst_valid), 32'h0);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("to_err_clr", 32'(fetch_err), 32'h0);
        check("to_addr", 32'(bus.imem_addr), 32'h03F0);
        repeat (14) step();
        bus.imem_ack = 1'b1; bus.imem_data = 16'hBEEF;
        step();
        bus.imem_ack = 1'b0;
        check("to_edge_inst", 32'(inst), 32'hBEEF);
        check("to_edge_valid", 32'(inst_valid), 32'h1);
        check("to_edge_req", 32'(bus.imem_req), 32'h0);
        step();
        check("to_edge_err", 32'(fetch_err), 32'h0);

        // Pc_Rst abort with simultaneous load edge
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("ab_req", 32'(bus.imem_req), 32'h1);
        step();
        Pc_Rst = 1'b0; Pc_Ld = 1'b1; pc_addr_sel = 1'b0; alu_pc_in = 16'h0009;
        step();
        Pc_Rst = 1'b1; Pc_Ld = 1'b0;
        check("ab_pc", 32'(pc), 32'h0);
        check("ab_req_clr", 32'(bus.imem_req), 32'h0);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_valid", 32'(inst_valid), 32'h0);
        check("ab_inst", 32'(inst), 32'hBEEF);
        bus.imem_ack = 1'b1; bus.imem_data = 16'h7777;
        step();
        bus.imem_ack = 1'b0;
        check("ab_late_inst", 32'(inst), 32'hBEEF);
        check("ab_late_valid", 32'(inst_valid), 32'h0);

        // PC load during an in-flight fetch
        Pc_Ld = 1'b1; pc_addr_sel = 1'b0; alu_pc_in = 16'h0020;
        step();
        Pc_Ld = 1'b0;
        check("if_pc", 32'(pc), 32'h0020);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("if_addr", 32'(bus.imem_addr), 32'h0020);
        pc_addr_sel = 1'b1; imd_addr = 16'h0010; Pc_Ld = 1'b1;
        step();
        Pc_Ld = 1'b0;
        check("if_pc_new", 32'(pc), 32'h0010);
        check("if_addr_hold", 32'(bus.imem_addr), 32'h0020);
        check("if_req_hold", 32'(bus.imem_req), 32'h1);
        bus.imem_ack = 1'b1; bus.imem_data = 16'h5A5A;
        step();
        bus.imem_ack = 1'b0;
        check("if_inst", 32'(inst), 32'h5A5A);
        check("if_addr_end", 32'(bus.imem_addr), 32'h0020);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("if_next_addr", 32'(bus.imem_addr), 32'h0010);
        bus.imem_ack = 1'b1; bus.imem_data = 16'hA5A5;
        step();
        bus.imem_ack = 1'b0;
        check("if_next_inst", 32'(inst), 32'hA5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Holds the program counter and instruction register, and fetches 16-bit instruction words from instruction memory over a req/ack handshake. It sits directly upstream of the control unit:
- it drives the control unit's `inst` input;
- it consumes the control unit's `Pc_Rst`, `Pc_Ld` and `pc_addr_sel` outputs and its 16-bit `imd_addr` branch target.

The incremented PC arrives from the ALU result bus during the control unit's increment-PC step.

## Interface
- `PC_W`, 16, program counter / instruction address width
- `IW`, 16, instruction word width
- `TIMEOUT`, 15, maximum clock edges to wait for `imem_ack` after raising `imem_req` (1..255)
- `clk` input 1: clock, all logic on rising edge
- `Rst` input 1: reset, asynchronous, active-low
- `Pc_Rst` input 1: synchronous PC clear, active-low, from control unit
- `Pc_Ld` input 1: PC load request, from control unit
- `pc_addr_sel` input 1: PC source select; 1 = `imd_addr`, 0 = `alu_pc_in`
- `imd_addr` input PC_W: branch/jump target
- `alu_pc_in` input PC_W: incremented PC from ALU result
- `fetch_req` input 1: start a fetch (level; sampled only in F_IDLE)
- `imem_ack` input 1: memory data valid
- `imem_data` input IW: instruction word from memory
- `imem_req` output 1: memory read request
- `imem_addr` output PC_W: memory read address
- `pc` output PC_W: current program counter
- `inst` output IW: instruction register, to control unit
- `inst_valid` output 1: `inst` holds the word fetched from the current fetch
- `busy` output 1: fetch in flight
- `fetch_err` output 1: last fetch timed out (sticky)

## Operation
**Reset.** `Rst` low (asynchronous) zeroes all of the following, and sets the FSM to F_IDLE:
- `pc`, `inst`, `imem_addr`, and the wait counter
- `inst_valid`, `imem_req`, `busy`, `fetch_err`

**PC register.**
- Priority order: `Rst` low > `Pc_Rst` low > `Pc_Ld` rising edge > hold.
- `Pc_Ld` is edge-detected against a registered copy (`pc_ld_q`, reset 0). A load occurs only on the edge where `Pc_Ld`=1 and `pc_ld_q`=0, so `Pc_Ld` held high for N cycles loads once.
- Load value: `pc_addr_sel` ? `imd_addr` : `alu_pc_in`, both sampled on the load edge. No width arithmetic is done inside the block.
- `Pc_Rst` low clears `pc` to 0. It also aborts any fetch: FSM to F_IDLE, `imem_req`=0, `busy`=0, `inst_valid`=0, `fetch_err`=0. `inst` is unchanged.

**Fetch FSM** (states F_IDLE, F_REQ, F_ERR).
- **F_IDLE:**
  - If `fetch_req`=1, go to F_REQ.
  - On that edge: `imem_addr`←`pc`, `imem_req`←1, `busy`←1, `inst_valid`←0, `fetch_err`←0, wait counter←0.
- **F_REQ:**
  - If `imem_ack`=1: `inst`←`imem_data`, `inst_valid`←1, `imem_req`←0, `busy`←0, go to F_IDLE.
  - Else if counter = `TIMEOUT`−1: `imem_req`←0, go to F_ERR.
  - Else increment counter.
- **F_ERR** (one cycle): `fetch_err`←1, `busy`←0, `inst` unchanged, `inst_valid` stays 0, go to F_IDLE.
- `imem_addr` is held stable for the whole of F_REQ. A PC load during F_REQ updates `pc` but not the in-flight address.
- `fetch_req` is ignored outside F_IDLE. There is no queuing.
- `imem_ack` is ignored outside F_REQ.

## Timing
- `fetch_req` sampled high at edge N: `imem_req`=1 after N.
- `imem_ack` sampled high at edge N+k (k≥1): `inst`/`inst_valid` valid after N+k. Minimum latency is 2 edges from `fetch_req` to `inst_valid`.
- With no ack: `imem_req` drops after edge N+`TIMEOUT`, and `fetch_err` rises after edge N+`TIMEOUT`+1.
- `imem_ack` arriving on the same edge as the timeout compare wins: the fetch succeeds.
- PC load is visible on `pc` one edge after the `Pc_Ld` rising sample.
- `Pc_Rst` low and a `Pc_Ld` edge in the same cycle: `pc`=0.
- `inst_valid`, once high, stays high until the next accepted `fetch_req` or `Pc_Rst`.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- **Reset mid-fetch:** `Rst` low while in F_REQ → all outputs 0 immediately (asynchronous); after release, `fetch_req`=1 → `imem_req`=1, `imem_addr`=0x0000.
- **Basic fetch:** `pc`=0x0004, `fetch_req` pulse, ack 3 cycles later with `imem_data`=0x2465 → `inst`=0x2465, `inst_valid`=1, `busy`=0, `imem_req` low the same edge.
- **PC load and edge detection:**
  - `pc_addr_sel`=0, `alu_pc_in`=0x0005, `Pc_Ld` held high 3 cycles → `pc`=0x0005, loaded once.
  - Then `pc_addr_sel`=1, `imd_addr`=0x03F0, new `Pc_Ld` pulse → `pc`=0x03F0.
- **Timeout:** `TIMEOUT`=15, no ack → `imem_req` drops after 15 edges; `fetch_err`=1 one edge later; `inst` keeps its old value.
  - Next `fetch_req` clears `fetch_err`.
  - Ack on exactly the 15th edge → success, no error.
- **Pc_Rst abort with simultaneous load:** `Pc_Rst` low during F_REQ together with a `Pc_Ld` edge (`alu_pc_in`=0x0009) → `pc`=0, FSM F_IDLE, `imem_req`=0; a late `imem_ack` is ignored.
- **PC load during an in-flight fetch:** `Pc_Ld` edge during F_REQ with `imd_addr`=0x0010 and `pc_addr_sel`=1 → `pc`=0x0010 while `imem_addr` holds the original address until ack.
